// File: rtl/slot_alloc_32_pkg.sv
// Shared types and constants for the 32-entry slot allocator.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package slot_alloc_32_pkg;

    localparam int ALLOC_ENTRIES = 32;
    localparam int ALLOC_IDX_W   = 5;
    localparam int ALLOC_CNT_W   = 6;

    typedef logic [ALLOC_IDX_W-1:0]   alloc_idx_t;
    typedef logic [ALLOC_ENTRIES-1:0] alloc_vec_t;
    typedef logic [ALLOC_CNT_W-1:0]   alloc_cnt_t;

    // Free vector after reset or flush: reserved low slots are permanently busy.
    function automatic alloc_vec_t reset_free_mask(input int reserved);
        alloc_vec_t m;
        for (int i = 0; i < ALLOC_ENTRIES; i++) begin
            m[i] = (i >= reserved);
        end
        return m;
    endfunction

    // Matching free count for the mask above.
    function automatic alloc_cnt_t reset_free_count(input int reserved);
        return alloc_cnt_t'(ALLOC_ENTRIES - reserved);
    endfunction

endpackage

// File: rtl/priority_encoder_32.sv
// 32-input priority encoder: index of the first input equal to SIGNAL.
// Latency: purely combinational, zero cycles.
// Backpressure: none; valid=0 and idx=0 when no input matches.
//
// Ports:
//   in_vec  unpacked 32-entry input vector
//   idx     selected index (lowest first when HIGH_PRIORITY=0, highest otherwise)
//   valid   at least one input equals SIGNAL
module priority_encoder_32
    import slot_alloc_32_pkg::*;
#(
    parameter bit SIGNAL        = 1'b1,
    parameter bit HIGH_PRIORITY = 1'b0
) (
    input  logic                   in_vec [ALLOC_ENTRIES],
    output logic [ALLOC_IDX_W-1:0] idx,
    output logic                   valid
);

    // The loop runs from the lowest-priority end so the last match written wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        if (HIGH_PRIORITY) begin
            for (int i = 0; i < ALLOC_ENTRIES; i++) begin
                if (in_vec[i] == SIGNAL) begin
                    idx   = alloc_idx_t'(i);
                    valid = 1'b1;
                end
            end
        end else begin
            for (int i = ALLOC_ENTRIES - 1; i >= 0; i--) begin
                if (in_vec[i] == SIGNAL) begin
                    idx   = alloc_idx_t'(i);
                    valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/slot_alloc_32.sv
// Slot allocator for a 32-entry out-of-order structure: grants free slots, accepts releases.
// Latency: grant is combinational from registered state; alloc/release/flush visible next cycle.
// Backpressure: alloc_ready=0 when no slot is free; requests while not ready are dropped.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   alloc_req          dispatch wants a slot this cycle
//   alloc_ready        at least one slot free
//   alloc_idx          offered slot (0 when not ready)
//   release_valid/idx  return one slot
//   flush              restore reset occupancy (error flag kept)
//   free_count         number of free slots, 0..32
//   release_err        sticky illegal-release flag
module slot_alloc_32
    import slot_alloc_32_pkg::*;
#(
    parameter bit HIGH_PRIORITY    = 1'b0,
    parameter int RESERVED_ENTRIES = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alloc_req,
    output logic                   alloc_ready,
    output logic [ALLOC_IDX_W-1:0] alloc_idx,
    input  logic                   release_valid,
    input  logic [ALLOC_IDX_W-1:0] release_idx,
    input  logic                   flush,
    output logic [ALLOC_CNT_W-1:0] free_count,
    output logic                   release_err
);

    localparam alloc_vec_t FREE_INIT  = reset_free_mask(RESERVED_ENTRIES);
    localparam alloc_cnt_t COUNT_INIT = reset_free_count(RESERVED_ENTRIES);

    alloc_vec_t free_q, free_d;
    alloc_cnt_t count_q, count_d;
    logic       err_q, err_d;

    logic       free_unp [ALLOC_ENTRIES];
    alloc_idx_t enc_idx;
    logic       enc_vld;

    logic       alloc_fire;
    logic       rel_illegal;
    logic       rel_fire;

    always_comb begin
        for (int i = 0; i < ALLOC_ENTRIES; i++) begin
            free_unp[i] = free_q[i];
        end
    end

    priority_encoder_32 #(
        .SIGNAL        (1'b1),
        .HIGH_PRIORITY (HIGH_PRIORITY)
    ) u_enc (
        .in_vec (free_unp),
        .idx    (enc_idx),
        .valid  (enc_vld)
    );

    assign alloc_ready = enc_vld;
    assign alloc_idx   = enc_idx;
    assign free_count  = count_q;
    assign release_err = err_q;

    assign alloc_fire = alloc_req && enc_vld;

    // Reserved slots are exactly the zero bits of the reset mask, so that test
    // covers the index range check without a comparison against zero.
    // Releasing the slot being granted this cycle is caught by the free_q check,
    // since the grant has not yet cleared it.
    assign rel_illegal = release_valid && (free_q[release_idx] || !FREE_INIT[release_idx]);
    assign rel_fire    = release_valid && !rel_illegal;

    always_comb begin
        free_d  = free_q;
        count_d = count_q;
        err_d   = err_q;
        if (flush) begin
            free_d  = FREE_INIT;
            count_d = COUNT_INIT;
        end else begin
            err_d = err_q | rel_illegal;
            if (alloc_fire) begin
                free_d[enc_idx] = 1'b0;
            end
            if (rel_fire) begin
                free_d[release_idx] = 1'b1;
            end
            case ({alloc_fire, rel_fire})
                2'b10:   count_d = count_q - alloc_cnt_t'(1);
                2'b01:   count_d = count_q + alloc_cnt_t'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_q  <= FREE_INIT;
            count_q <= COUNT_INIT;
            err_q   <= 1'b0;
        end else begin
            free_q  <= free_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_slot_alloc_32.sv
// Testbench for slot_alloc_32: two configurations driven by shared stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_slot_alloc_32;

    logic       clk;
    logic       rst_n;
    logic       alloc_req;
    logic       release_valid;
    logic [4:0] release_idx;
    logic       flush;

    logic       a_ready, b_ready;
    logic [4:0] a_idx, b_idx;
    logic [5:0] a_cnt, b_cnt;
    logic       a_err, b_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: per-instance free flags, sticky error, configuration.
    bit mfree [2][32];
    bit merr  [2];
    int mres  [2] = '{0, 4};
    bit mhp   [2] = '{1'b0, 1'b1};

    slot_alloc_32 #(.HIGH_PRIORITY(1'b0), .RESERVED_ENTRIES(0)) u_a (
        .clk(clk), .rst_n(rst_n), .alloc_req(alloc_req), .alloc_ready(a_ready),
        .alloc_idx(a_idx), .release_valid(release_valid), .release_idx(release_idx),
        .flush(flush), .free_count(a_cnt), .release_err(a_err)
    );

    slot_alloc_32 #(.HIGH_PRIORITY(1'b1), .RESERVED_ENTRIES(4)) u_b (
        .clk(clk), .rst_n(rst_n), .alloc_req(alloc_req), .alloc_ready(b_ready),
        .alloc_idx(b_idx), .release_valid(release_valid), .release_idx(release_idx),
        .flush(flush), .free_count(b_cnt), .release_err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset_occ(input int k);
        for (int i = 0; i < 32; i++) mfree[k][i] = (i >= mres[k]);
    endfunction

    function automatic int model_count(input int k);
        int n = 0;
        for (int i = 0; i < 32; i++) n += mfree[k][i];
        return n;
    endfunction

    // First free slot in the instance's priority order, -1 when none.
    function automatic int model_pick(input int k);
        if (mhp[k]) begin
            for (int i = 31; i >= 0; i--) if (mfree[k][i]) return i;
        end else begin
            for (int i = 0; i < 32; i++) if (mfree[k][i]) return i;
        end
        return -1;
    endfunction

    function automatic void model_edge(input bit req, input bit rv, input int ridx, input bit fl);
        for (int k = 0; k < 2; k++) begin
            int  g;
            bit  bad;
            g = model_pick(k);
            if (fl) begin
                model_reset_occ(k);
            end else begin
                bad = rv && ((ridx < mres[k]) || mfree[k][ridx]);
                if (bad) merr[k] = 1'b1;
                if (req && g >= 0) mfree[k][g] = 1'b0;
                if (rv && !bad) mfree[k][ridx] = 1'b1;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        int ga, gb;
        ga = model_pick(0);
        gb = model_pick(1);
        chk("a_ready", 32'(a_ready), 32'(ga >= 0));
        chk("a_idx",   32'(a_idx),   (ga >= 0) ? 32'(ga) : 32'd0);
        chk("a_count", 32'(a_cnt),   32'(model_count(0)));
        chk("a_err",   32'(a_err),   32'(merr[0]));
        chk("b_ready", 32'(b_ready), 32'(gb >= 0));
        chk("b_idx",   32'(b_idx),   (gb >= 0) ? 32'(gb) : 32'd0);
        chk("b_count", 32'(b_cnt),   32'(model_count(1)));
        chk("b_err",   32'(b_err),   32'(merr[1]));
    endtask

    // One clock: drive at negedge, model at posedge, check just after.
    task automatic step(input bit req, input bit rv, input int ridx, input bit fl);
        alloc_req     = req;
        release_valid = rv;
        release_idx   = 5'(ridx);
        flush         = fl;
        @(posedge clk);
        model_edge(req, rv, ridx, fl);
        #1;
        check_all();
        @(negedge clk);
        alloc_req     = 1'b0;
        release_valid = 1'b0;
        flush         = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        alloc_req     = 1'b0;
        release_valid = 1'b0;
        release_idx   = '0;
        flush         = 1'b0;
        for (int k = 0; k < 2; k++) begin
            model_reset_occ(k);
            merr[k] = 1'b0;
        end
        #12;
        // Reset values of both configurations.
        chk("rst_a_count", 32'(a_cnt), 32'd32);
        chk("rst_a_idx",   32'(a_idx), 32'd0);
        chk("rst_b_count", 32'(b_cnt), 32'd28);
        chk("rst_b_idx",   32'(b_idx), 32'd31);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill A completely; grants come out in ascending order.
        for (int i = 0; i < 32; i++) begin
            chk("a_grant_order", 32'(a_idx), 32'(i));
            step(1'b1, 1'b0, 0, 1'b0);
        end
        chk("full_ready", 32'(a_ready), 32'd0);
        chk("full_count", 32'(a_cnt), 32'd0);
        step(1'b1, 1'b0, 0, 1'b0);
        chk("req_when_full", 32'(a_cnt), 32'd0);

        // Release into a full allocator, then take it back.
        step(1'b0, 1'b1, 17, 1'b0);
        chk("rel17_idx", 32'(a_idx), 32'd17);
        chk("rel17_count", 32'(a_cnt), 32'd1);
        step(1'b1, 1'b0, 0, 1'b0);
        chk("realloc17_count", 32'(a_cnt), 32'd0);

        // Free 3..8, then alloc (grants 3) with a release of busy slot 9.
        for (int s = 3; s <= 8; s++) step(1'b0, 1'b1, s, 1'b0);
        chk("pre_simul_idx", 32'(a_idx), 32'd3);
        step(1'b1, 1'b1, 9, 1'b0);
        chk("simul_count", 32'(a_cnt), 32'd6);
        for (int s = 0; s < 5; s++) step(1'b1, 1'b0, 0, 1'b0);
        chk("released9_idx", 32'(a_idx), 32'd9);

        // Flush, then release an already free slot.
        step(1'b0, 1'b0, 0, 1'b1);
        chk("flush_count", 32'(a_cnt), 32'd32);
        step(1'b0, 1'b1, 5, 1'b0);
        chk("dup_rel_err", 32'(a_err), 32'd1);
        chk("dup_rel_count", 32'(a_cnt), 32'd32);
        step(1'b0, 1'b0, 0, 1'b0);
        chk("err_sticky", 32'(a_err), 32'd1);

        // Asynchronous reset in the middle of an allocation burst.
        for (int s = 0; s < 3; s++) step(1'b1, 1'b0, 0, 1'b0);
        alloc_req = 1'b1;
        @(posedge clk);
        model_edge(1'b1, 1'b0, 0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_a_count", 32'(a_cnt), 32'd32);
        chk("arst_a_err",   32'(a_err), 32'd0);
        chk("arst_b_count", 32'(b_cnt), 32'd28);
        chk("arst_b_idx",   32'(b_idx), 32'd31);
        for (int k = 0; k < 2; k++) begin
            model_reset_occ(k);
            merr[k] = 1'b0;
        end
        check_all();
        @(negedge clk);
        alloc_req = 1'b0;
        rst_n     = 1'b1;

        // Reserved slot release is illegal in B.
        step(1'b0, 1'b1, 2, 1'b0);
        chk("b_reserved_err", 32'(b_err), 32'd1);
        chk("b_reserved_count", 32'(b_cnt), 32'd28);

        // Ten allocations, then flush alongside alloc and release.
        for (int s = 0; s < 10; s++) step(1'b1, 1'b0, 0, 1'b0);
        chk("ten_alloc_count", 32'(a_cnt), 32'd22);
        step(1'b1, 1'b1, 7, 1'b1);
        chk("flush_prio_count", 32'(a_cnt), 32'd32);
        chk("flush_prio_idx", 32'(a_idx), 32'd0);

        // Randomised traffic against the model.
        for (int c = 0; c < 600; c++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 31)), 1'($urandom_range(0, 40) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
